// File: rtl/mem_skew_feeder_pkg.sv
// Shared types and index helpers for the skewed operand feeder.
// Keeps beat count and lane/element arithmetic in one place.
package mem_skew_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } feeder_state_t;

    // Number of beats needed to skew a dim x dim matrix.
    function automatic int beats(input int dim);
        return 2 * dim - 1;
    endfunction

    // Element index carried by lane r on beat t.
    function automatic int lane_k(input int t, input int r);
        return t - r;
    endfunction

    function automatic bit in_window(input int k, input int dim);
        return (k >= 0) && (k < dim);
    endfunction

    // Bit offset of element (row, col) in the flattened matrix.
    function automatic int elem_base(
        input int row,
        input int col,
        input int dim,
        input int bits
    );
        return (row * dim + col) * bits;
    endfunction

endpackage

// File: rtl/mem_skew_feeder_if.sv
// Load/stream bundle between the feeder and its producer/consumer.
// master drives writes and control, slave is the feeder itself.
interface mem_skew_feeder_if #(
    parameter int BITS_AB = 8,
    parameter int DIM     = 8
);
    localparam int ROW_W = $clog2(DIM);

    logic                   wr_en;
    logic [ROW_W-1:0]       wr_row;
    logic [DIM*BITS_AB-1:0] wr_data;
    logic                   start;
    logic                   transpose;
    logic                   stall;
    logic                   busy;
    logic                   out_valid;
    logic [DIM*BITS_AB-1:0] out_vec;
    logic                   done;

    modport master (
        output wr_en, wr_row, wr_data,
        output start, transpose, stall,
        input  busy, out_valid, out_vec, done
    );

    modport slave (
        input  wr_en, wr_row, wr_data,
        input  start, transpose, stall,
        output busy, out_valid, out_vec, done
    );

endinterface

// File: rtl/mem_skew_feeder_skew_select.sv
// Combinational lane selector: picks the diagonal slice of the matrix
// for one beat, in normal (row) or transposed (column) orientation.
module mem_skew_feeder_skew_select
    import mem_skew_feeder_pkg::*;
#(
    parameter int BITS_AB = 8,
    parameter int DIM     = 8,
    parameter int TW      = 4
) (
    input  logic [TW-1:0]              t,
    input  logic                       mode,
    input  logic [DIM*DIM*BITS_AB-1:0] mat,
    output logic [DIM*BITS_AB-1:0]     vec
);

    // Lane r carries element k=t-r; lanes outside the window read zero.
    always_comb begin : sel
        int k;
        vec = '0;
        k = 0;
        for (int r = 0; r < DIM; r++) begin
            k = lane_k(int'(t), r);
            if (in_window(k, DIM)) begin
                if (mode)
                    vec[r*BITS_AB +: BITS_AB] =
                        mat[elem_base(k, r, DIM, BITS_AB) +: BITS_AB];
                else
                    vec[r*BITS_AB +: BITS_AB] =
                        mat[elem_base(r, k, DIM, BITS_AB) +: BITS_AB];
            end
        end
    end

endmodule

// File: rtl/mem_skew_feeder.sv
// Operand memory that streams a DIM x DIM matrix as skewed lane
// vectors for a systolic array, with transpose, stall and done pulse.
module mem_skew_feeder
    import mem_skew_feeder_pkg::*;
#(
    parameter int BITS_AB = 8,
    parameter int DIM     = 8
) (
    input logic               clk,
    input logic               rst,
    mem_skew_feeder_if.slave  bus
);

    localparam int TW = $clog2(beats(DIM));
    localparam int VW = DIM * BITS_AB;
    localparam int MW = DIM * DIM * BITS_AB;
    localparam logic [TW-1:0] T_LAST = TW'(beats(DIM) - 1);

    feeder_state_t state_q, state_d;
    logic [TW-1:0] t_q, t_d;
    logic          mode_q, mode_d;
    logic [MW-1:0] mem_q, mem_d;
    logic [VW-1:0] vec_q;
    logic [VW-1:0] sel_vec;

    // Next state, beat counter, mode latch and row writes (IDLE only).
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        mode_d  = mode_q;
        mem_d   = mem_q;
        unique case (state_q)
            IDLE: begin
                if (bus.wr_en && (int'(bus.wr_row) < DIM))
                    mem_d[int'(bus.wr_row)*VW +: VW] = bus.wr_data;
                if (bus.start) begin
                    state_d = STREAM;
                    t_d     = '0;
                    mode_d  = bus.transpose;
                end
            end
            STREAM: begin
                if (!bus.stall) begin
                    if (t_q == T_LAST)
                        state_d = DONE;
                    else
                        t_d = t_q + 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Selector looks at next-cycle values so a row written together
    // with start already shows up in the first registered beat.
    mem_skew_feeder_skew_select #(
        .BITS_AB (BITS_AB),
        .DIM     (DIM),
        .TW      (TW)
    ) u_sel (
        .t    (t_d),
        .mode (mode_d),
        .mat  (mem_d),
        .vec  (sel_vec)
    );

    // State, memory and registered output beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            t_q     <= '0;
            mode_q  <= 1'b0;
            mem_q   <= '0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            mode_q  <= mode_d;
            mem_q   <= mem_d;
            vec_q   <= (state_d == STREAM) ? sel_vec : '0;
        end
    end

    assign bus.busy      = (state_q == STREAM);
    assign bus.out_valid = (state_q == STREAM);
    assign bus.done      = (state_q == DONE);
    assign bus.out_vec   = vec_q;

endmodule

// File: tb/tb_mem_skew_feeder.sv
// Directed bench for mem_skew_feeder: DIM=8 streams in both
// orientations, stall, ignored writes/starts, reset, and DIM=2.
module tb_mem_skew_feeder;

    localparam int NONE = -100;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mem_skew_feeder_if #(.BITS_AB(8), .DIM(8)) bus8 ();
    mem_skew_feeder_if #(.BITS_AB(4), .DIM(2)) bus2 ();

    mem_skew_feeder #(.BITS_AB(8), .DIM(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    mem_skew_feeder #(.BITS_AB(4), .DIM(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [63:0] vals [0:39];
    int          nvalid;
    bit          done_seen;
    int          done_after;
    bit          busy_ok;
    bit          rst_hit;

    task automatic chk(
        input string       tag,
        input logic [63:0] got,
        input logic [63:0] exp
    );
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One DIM=8 stream; indices refer to the valid beat on screen.
    task automatic run(
        input logic md,
        input int   st_from,
        input int   st_n,
        input int   xs_at,
        input int   wr_at,
        input bit   wr_start,
        input int   rst_at
    );
        int cur;
        nvalid     = 0;
        done_seen  = 0;
        done_after = -1;
        busy_ok    = 1;
        rst_hit    = 0;
        bus8.start     = 1'b1;
        bus8.transpose = md;
        if (wr_start) begin
            bus8.wr_en   = 1'b1;
            bus8.wr_row  = 3'd2;
            bus8.wr_data = {8{8'hFB}};
        end
        tick();
        bus8.start = 1'b0;
        bus8.wr_en = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus8.done) begin
                done_seen  = 1;
                done_after = nvalid;
                break;
            end
            if (bus8.out_valid) begin
                vals[nvalid] = bus8.out_vec;
                if (!bus8.busy) busy_ok = 0;
                nvalid++;
            end
            cur = nvalid - 1;
            bus8.stall = (cur >= st_from) && (cur < st_from + st_n);
            bus8.start = (cur == xs_at);
            if (cur == wr_at) begin
                bus8.wr_en   = 1'b1;
                bus8.wr_row  = 3'd2;
                bus8.wr_data = {8{8'hFB}};
            end else begin
                bus8.wr_en = 1'b0;
            end
            if (cur == rst_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                rst_hit = 1;
                break;
            end
            tick();
        end
        bus8.stall = 1'b0;
        bus8.start = 1'b0;
        bus8.wr_en = 1'b0;
        if (done_seen) begin
            chk("done_no_valid", bus8.out_valid, 0);
            tick();
            chk("done_pulse", bus8.done, 0);
        end
    endtask

    logic [7:0]  v2 [0:9];
    int          n2;
    bit          d2;
    logic [63:0] acc;

    initial begin
        bus8.wr_en = 0; bus8.wr_row = 0; bus8.wr_data = 0;
        bus8.start = 0; bus8.transpose = 0; bus8.stall = 0;
        bus2.wr_en = 0; bus2.wr_row = 0; bus2.wr_data = 0;
        bus2.start = 0; bus2.transpose = 0; bus2.stall = 0;

        rst = 1'b1;
        tick();
        tick();
        chk("rst_busy", bus8.busy, 0);
        chk("rst_valid", bus8.out_valid, 0);
        chk("rst_done", bus8.done, 0);
        chk("rst_vec", bus8.out_vec, 0);
        rst = 1'b0;
        tick();

        for (int r = 0; r < 8; r++) begin
            bus8.wr_en  = 1'b1;
            bus8.wr_row = 3'(r);
            for (int c = 0; c < 8; c++)
                bus8.wr_data[c*8 +: 8] = 8'(r * 8 + c);
            tick();
        end
        bus8.wr_en = 1'b0;

        run(1'b0, NONE, 0, NONE, NONE, 0, NONE);
        chk("n_done", done_seen, 1);
        chk("n_count", nvalid, 15);
        chk("n_done_at", done_after, 15);
        chk("n_b0", vals[0], 64'h0);
        chk("n_b7", vals[7], 64'h38312A231C150E07);
        chk("n_b14", vals[14], 64'h3F00000000000000);

        run(1'b1, NONE, 0, NONE, NONE, 0, NONE);
        chk("t_count", nvalid, 15);
        chk("t_b1", vals[1], 64'h0108);
        chk("t_b7", vals[7], 64'h070E151C232A3138);

        run(1'b0, 4, 3, 2, NONE, 0, NONE);
        chk("s_count", nvalid, 18);
        chk("s_done_at", done_after, 18);
        chk("s_busy", busy_ok, 1);
        for (int i = 4; i < 8; i++)
            chk("s_hold", vals[i], 64'h0000002019120B04);
        chk("s_b5", vals[8], 64'h000028211A130C05);

        run(1'b0, NONE, 0, NONE, 3, 0, NONE);
        chk("w_strm_count", nvalid, 15);
        run(1'b0, NONE, 0, NONE, NONE, 0, NONE);
        chk("w_ign_b2", vals[2][23:16], 8'h10);
        chk("w_ign_b9", vals[9][23:16], 8'h17);

        run(1'b0, NONE, 0, NONE, NONE, 1, NONE);
        chk("w_idle_b2", vals[2][23:16], 8'hFB);
        chk("w_idle_b3", vals[3][23:16], 8'hFB);
        chk("w_idle_b2_l1", vals[2][15:8], 8'h09);

        run(1'b0, NONE, 0, NONE, NONE, 0, 6);
        chk("r_hit", rst_hit, 1);
        chk("r_busy", bus8.busy, 0);
        chk("r_valid", bus8.out_valid, 0);
        chk("r_vec", bus8.out_vec, 0);
        chk("r_done", bus8.done, 0);
        tick();
        chk("r_done_next", bus8.done, 0);

        run(1'b0, NONE, 0, NONE, NONE, 0, NONE);
        acc = '0;
        for (int i = 0; i < 15; i++) acc |= vals[i];
        chk("z_count", nvalid, 15);
        chk("z_all", acc, 0);

        bus2.wr_en   = 1'b1;
        bus2.wr_row  = 1'b0;
        bus2.wr_data = {4'h7, 4'h8};
        tick();
        bus2.wr_row  = 1'b1;
        bus2.wr_data = {4'hF, 4'h3};
        tick();
        bus2.wr_en     = 1'b0;
        bus2.start     = 1'b1;
        bus2.transpose = 1'b0;
        tick();
        bus2.start = 1'b0;
        n2 = 0;
        d2 = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus2.done) begin
                d2 = 1;
                break;
            end
            if (bus2.out_valid && n2 < 10) begin
                v2[n2] = bus2.out_vec;
                n2++;
            end
            tick();
        end
        chk("d2_done", d2, 1);
        chk("d2_count", n2, 3);
        chk("d2_b0", v2[0], 8'h08);
        chk("d2_b1", v2[1], 8'h37);
        chk("d2_b2", v2[2], 8'hF0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_skew_feeder.md
Name: mem_skew_feeder

Overview:
- Parametrised operand memory for the systolic-array datapath.
- Holds a DIM x DIM signed matrix that is loaded one row per cycle.
- On start, streams the matrix as diagonally skewed lane vectors over 2*DIM-1 beats, in normal or transposed orientation.
- Successor to the fixed A-only row generator; adds transpose mode, stall, and a start/done handshake so it can feed either the A or the B side of the array.

Parameters:
- BITS_AB, 8, signed element width.
- DIM, 8, matrix dimension and lane count (>=2).
- ROW_W, $clog2(DIM), derived; row index width (not overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- wr_en  in  1  write one row.
- wr_row  in  ROW_W  row index to write.
- wr_data  in  DIM*BITS_AB  row data; element c at bits [c*BITS_AB +: BITS_AB].
- start  in  1  begin a stream (honoured only in IDLE).
- transpose  in  1  stream orientation, sampled when start is accepted.
- stall  in  1  freeze the stream (hold the current beat).
- busy  out  1  high in STREAM.
- out_valid  out  1  out_vec carries a beat.
- out_vec  out  DIM*BITS_AB  lane r at bits [r*BITS_AB +: BITS_AB].
- done  out  1  one-cycle pulse after the last beat.

Behaviour:
- Reset (synchronous, active-high, wins over all other inputs):
  - state=IDLE, beat counter t=0.
  - busy, out_valid, done = 0; out_vec = 0.
  - All matrix entries cleared to 0.
- Writes:
  - Accepted only in IDLE; ignored in STREAM/DONE.
  - The row is committed at the clock edge.
  - wr_en and start in the same IDLE cycle: the write is committed and is visible in the stream.
- States:
  - IDLE: on start, latch transpose into mode, t=0, go to STREAM.
  - STREAM: registered outputs, out_valid=1, busy=1.
  - DONE: done=1, out_valid=0; next cycle go to IDLE.
- Beat contents (beat t, lane r, k=t-r):
  - Normal mode: A[r][k] if 0<=k<DIM, else 0.
  - Transpose mode: A[k][r] if 0<=k<DIM, else 0.
  - First beat t=0 appears the cycle after start is accepted. Latency is 1 cycle.
  - Beats t=0..2*DIM-2, one per non-stalled cycle.
- Stall in STREAM: t, out_vec and out_valid hold; no beat is consumed.
- Counter:
  - t advances only when stall=0.
  - Reaching t=2*DIM-2 and advancing moves to DONE; there is no wrap.
- start while busy or in DONE is ignored; no restart or queueing.
- stall outside STREAM has no effect.
- Reset mid-stream: the next cycle is IDLE with zeroed outputs and memory. No done pulse is produced.
- Elements pass unmodified (signed, no arithmetic). Out-of-window lanes output exactly 0.

Decomposition:
- mem_pkg:
  - feeder_state_t enum {IDLE, STREAM, DONE}.
  - Localparam-style functions: beats(DIM)=2*DIM-1 and lane index helpers.
- One natural sub-module: skew_select. Purely combinational; given t, mode and the matrix, produces out_vec. It is instantiated once and keeps the FSM file small.

Test Plan:
- Stimulus: DIM=8, load A[r][c]=r*8+c, start, transpose=0. Response:
  - Beat 0 = {0,0,...,0} with lane0=0.
  - Beat 7 = lanes {7,14,21,28,35,42,49,56}.
  - Beat 14 = lane7 only, value 63; all others 0.
  - done pulses the cycle after beat 14; 15 valid beats in total.
- Same matrix, transpose=1. Response: beat 1 = lane0=8, lane1=1, rest 0; beat 7 = lanes {56,49,42,35,28,21,14,7}.
- Stall held 3 cycles at beat 4, with a start pulse during the stream. Response:
  - out_vec stays at beat 4 for 4 cycles total.
  - Total valid cycles = 18.
  - The extra start has no effect and busy stays high throughout.
- Write row 2 = all -5 during STREAM. Response: ignored; a following stream still shows the original row 2 (16..23). The same write in IDLE together with start is visible: beat 2 lane2 = -5.
- Assert rst at beat 6. Response: next cycle busy=0, out_valid=0, out_vec=0, no done. A new stream without reloading produces all-zero beats.
- Edge parameter DIM=2, BITS_AB=4, A={{-8,7},{3,-1}}. Response: beats {-8,0}, {7,3}, {0,-1}, then done.
